// File: rtl/register_file.sv
// 32-entry architectural register file: r0 hardwired to zero, two combinational
// read ports with same-cycle write bypass, and a registered debug read port.
module register_file #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_wen,
    input  logic [4:0]       wr_reg,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [4:0]       rd_reg_a,
    input  logic [4:0]       rd_reg_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic [4:0]       dbg_reg,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] mem_q [32];
    logic [WIDTH-1:0] mem_d [32];
    logic [WIDTH-1:0] dbg_data_q;
    logic [WIDTH-1:0] dbg_data_d;
    logic             wr_live;

    // A write to r0 is dropped here, so entry 0 never leaves its reset value.
    assign wr_live = reg_wen && (wr_reg != 5'd0);

    always_comb begin
        mem_d = mem_q;
        if (wr_live) begin
            mem_d[wr_reg] = wr_data;
        end
    end

    // Debug sees the pre-edge contents, never the bypassed write data.
    always_comb begin
        dbg_data_d = mem_q[dbg_reg];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
            dbg_data_q <= '0;
        end else begin
            mem_q      <= mem_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    always_comb begin
        rd_data_a = '0;
        if (rd_reg_a != 5'd0) begin
            if (wr_live && (wr_reg == rd_reg_a)) begin
                rd_data_a = wr_data;
            end else begin
                rd_data_a = mem_q[rd_reg_a];
            end
        end
    end

    always_comb begin
        rd_data_b = '0;
        if (rd_reg_b != 5'd0) begin
            if (wr_live && (wr_reg == rd_reg_b)) begin
                rd_data_b = wr_data;
            end else begin
                rd_data_b = mem_q[rd_reg_b];
            end
        end
    end

    assign dbg_data = dbg_data_q;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: array model checked every negedge plus
// hand-computed literal expectations for reset, r0, bypass, debug latency and sweep.
module tb_register_file;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         reg_wen = 1'b0;
    logic [4:0]   wr_reg = '0;
    logic [W-1:0] wr_data = '0;
    logic [4:0]   rd_reg_a = '0;
    logic [4:0]   rd_reg_b = '0;
    logic [4:0]   dbg_reg = '0;
    logic [W-1:0] rd_data_a;
    logic [W-1:0] rd_data_b;
    logic [W-1:0] dbg_data;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] model [32];
    logic [W-1:0] model_dbg;
    bit           cmp_on = 1'b0;

    register_file #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .reg_wen   (reg_wen),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .rd_reg_a  (rd_reg_a),
        .rd_reg_b  (rd_reg_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .dbg_reg   (dbg_reg),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    // Model state: a plain array updated from the write rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
            model_dbg = '0;
        end else begin
            model_dbg = model[dbg_reg];
            if (reg_wen && wr_reg != 5'd0) model[wr_reg] = wr_data;
        end
    end

    function automatic logic [W-1:0] exp_port(input logic [4:0] idx);
        if (idx == 5'd0) return '0;
        if (reg_wen && wr_reg == idx) return wr_data;
        return model[idx];
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_a", rd_data_a, exp_port(rd_reg_a));
            check("model_b", rd_data_b, exp_port(rd_reg_b));
            check("model_dbg", dbg_data, model_dbg);
        end
    end

    // Waits for the next edge, then drives a full input vector 1 time unit after it.
    task automatic cycle(input logic wen, input logic [4:0] wr, input logic [W-1:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] dr);
        @(posedge clk);
        #1;
        reg_wen  = wen;
        wr_reg   = wr;
        wr_data  = wd;
        rd_reg_a = ra;
        rd_reg_b = rb;
        dbg_reg  = dr;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        model_dbg = '0;
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        check("reset_dbg", dbg_data, 8'h00);
        check("reset_a", rd_data_a, 8'h00);
        cmp_on = 1'b1;

        // Reset mid-cycle clears storage immediately
        cycle(1'b1, 5'd5, 8'hAA, 5'd5, 5'd0, 5'd5);
        cycle(1'b0, 5'd0, 8'h00, 5'd5, 5'd0, 5'd5);
        #1 check("pre_rst_a", rd_data_a, 8'hAA);
        #1 rst = 1'b1;
        #1 check("rst_async_a", rd_data_a, 8'h00);
        check("rst_async_dbg", dbg_data, 8'h00);
        rst = 1'b0;

        // Basic write/read
        cycle(1'b1, 5'd3, 8'h5C, 5'd0, 5'd0, 5'd0);
        cycle(1'b1, 5'd31, 8'hFF, 5'd0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 8'h00, 5'd3, 5'd31, 5'd0);
        #2 check("basic_a", rd_data_a, 8'h5C);
        check("basic_b", rd_data_b, 8'hFF);

        // r0 hardwire
        cycle(1'b1, 5'd0, 8'h7E, 5'd0, 5'd0, 5'd0);
        #2 check("r0_wr_a", rd_data_a, 8'h00);
        check("r0_wr_b", rd_data_b, 8'h00);
        cycle(1'b0, 5'd0, 8'h00, 5'd0, 5'd0, 5'd0);
        #2 check("r0_after_a", rd_data_a, 8'h00);
        cycle(1'b0, 5'd0, 8'h00, 5'd0, 5'd0, 5'd0);
        #2 check("r0_after_dbg", dbg_data, 8'h00);

        // Bypass, then no false bypass on a different write index
        cycle(1'b1, 5'd7, 8'h11, 5'd0, 5'd0, 5'd0);
        cycle(1'b1, 5'd7, 8'h22, 5'd7, 5'd7, 5'd0);
        #2 check("bypass_a", rd_data_a, 8'h22);
        check("bypass_b", rd_data_b, 8'h22);
        cycle(1'b1, 5'd8, 8'h55, 5'd7, 5'd7, 5'd0);
        #2 check("nobypass_a", rd_data_a, 8'h22);
        check("nobypass_b", rd_data_b, 8'h22);

        // Debug latency: sees pre-edge value
        cycle(1'b1, 5'd9, 8'h33, 5'd0, 5'd0, 5'd0);
        cycle(1'b1, 5'd9, 8'h44, 5'd0, 5'd0, 5'd9);
        cycle(1'b0, 5'd0, 8'h00, 5'd0, 5'd0, 5'd9);
        #2 check("dbg_old", dbg_data, 8'h33);
        cycle(1'b0, 5'd0, 8'h00, 5'd0, 5'd0, 5'd9);
        #2 check("dbg_new", dbg_data, 8'h44);

        // Sweep r1..r31 = 3*i mod 256, read pairs (i, 32-i)
        for (int i = 1; i < 32; i++) begin
            cycle(1'b1, 5'(i), W'((i * 3) % 256), 5'd0, 5'd0, 5'd0);
        end
        for (int i = 1; i < 32; i++) begin
            cycle(1'b0, 5'd0, 8'h00, 5'(i), 5'(32 - i), 5'(i));
            #2 check("sweep_a", rd_data_a, W'((i * 3) % 256));
            check("sweep_b", rd_data_b, W'(((32 - i) * 3) % 256));
        end

        // Bypass stays live during reset, and the write is lost
        cycle(1'b0, 5'd0, 8'h00, 5'd0, 5'd0, 5'd0);
        rst = 1'b1;
        cycle(1'b1, 5'd4, 8'h9A, 5'd4, 5'd5, 5'd4);
        #2 check("rst_bypass_a", rd_data_a, 8'h9A);
        check("rst_bypass_b", rd_data_b, 8'h00);
        cycle(1'b0, 5'd0, 8'h00, 5'd4, 5'd0, 5'd4);
        rst = 1'b0;
        #2 check("rst_lost_a", rd_data_a, 8'h00);
        cycle(1'b1, 5'd4, 8'h3C, 5'd0, 5'd0, 5'd4);
        cycle(1'b0, 5'd0, 8'h00, 5'd4, 5'd0, 5'd4);
        #2 check("post_rst_wr_a", rd_data_a, 8'h3C);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
